f_d_stage: RTL

//  Fetch stage plus F/D pipeline register for the 5-stage MIPS pipeline.
//  - Owns the PC and selects the next PC from the redirect sources computed in D.
//  - Presents PC_F to the external instruction memory and latches the returned

---
 rtl/f_d_stage_pkg.sv | 15 +
 rtl/f_d_stage_pc_reg.sv | 21 ++
 rtl/f_d_stage.sv | 90 +++++++++
 3 files changed

// File: rtl/f_d_stage_pkg.sv
// Shared constants for the fetch stage: next-PC select codes and the default
// reset/flush/instruction-memory window values also used by IM and CP0.
package f_d_stage_pkg;

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_FLUSH_PC = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_BYTES = 32'h0000_4000;

endpackage

// File: rtl/f_d_stage_pc_reg.sv
// Program counter flop: async active-low reset to RESET_PC, loads d when en.
// One-cycle update; holds its value whenever en is low.
module f_d_stage_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_PC;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/f_d_stage.sv
// Fetch stage and F/D pipeline register: owns the PC, picks the next PC, tags faults.
// One cycle from instr_F to IR_D; stall freezes PC and D, flush overrides stall.
module f_d_stage
    import f_d_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] FLUSH_PC = DEF_FLUSH_PC,
    parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
    parameter logic [31:0] IM_BYTES = DEF_IM_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] branch_tgt,
    input  logic [31:0] jump_tgt,
    input  logic [31:0] jr_tgt,
    input  logic [31:0] instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] IR_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic        exc_D,
    output logic        valid_D
);

    // Window end held at 33 bits so a window touching 2^32 cannot wrap.
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

    logic [31:0] npc;
    logic [31:0] pc_load;
    logic [31:0] pc_plus8;
    logic        fault_F;
    logic        pc_en;

    always_comb begin
        npc = PC_F + 32'd4;
        case (npc_sel)
            NPC_SEQ: npc = PC_F + 32'd4;
            NPC_BR:  npc = branch_tgt;
            NPC_J:   npc = jump_tgt;
            NPC_JR:  npc = jr_tgt;
            default: npc = PC_F + 32'd4;
        endcase
    end

    assign fault_F = (PC_F[1:0] != 2'b00)
                   | (PC_F < IM_BASE)
                   | ({1'b0, PC_F} >= IM_END);

    assign pc_plus8 = PC_F + 32'd8;
    assign pc_en    = ~stall | flush;
    assign pc_load  = flush ? ((flush_pc == 32'd0) ? FLUSH_PC : flush_pc) : npc;

    f_d_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_load),
        .q     (PC_F)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IR_D    <= 32'd0;
            PC_D    <= 32'd0;
            PC8_D   <= 32'd0;
            exc_D   <= 1'b0;
            valid_D <= 1'b0;
        end else if (flush) begin
            IR_D    <= 32'd0;
            PC_D    <= PC_F;
            PC8_D   <= pc_plus8;
            exc_D   <= 1'b0;
            valid_D <= 1'b0;
        end else if (!stall) begin
            // A faulted fetch still advances but carries a nop plus the fault tag.
            IR_D    <= fault_F ? 32'd0 : instr_F;
            PC_D    <= PC_F;
            PC8_D   <= pc_plus8;
            exc_D   <= fault_F;
            valid_D <= 1'b1;
        end
    end

endmodule
